// File: rtl/add_round_key.sv
// AES-128 AddRoundKey stage with on-chip round-key storage.
// The expanded key schedule is loaded one 32-bit word at a time. A round
// counter then selects which round key is XORed into each accepted state.
module add_round_key #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         key_load,
  input  logic [31:0]  key_word,
  output logic         key_ready,
  input  logic         start,
  input  logic         enable,
  input  logic [127:0] data_in,
  output logic [127:0] data_out,
  output logic [3:0]   round_out,
  output logic         valid_out,
  output logic         done
);

  localparam int NUM_KEYS  = NUM_ROUNDS + 1;
  localparam int NUM_WORDS = 4 * NUM_KEYS;
  localparam int WCNT_W    = $clog2(NUM_WORDS);

  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(NUM_WORDS - 1);
  localparam logic [3:0]        LAST_RND  = 4'(NUM_ROUNDS);

  logic [127:0]        rk [NUM_KEYS];
  logic [WCNT_W-1:0]   wcnt;
  logic [WCNT_W-3:0]   wr_rnd;
  logic [1:0]          wr_col;
  logic [3:0]          rnd;
  logic [3:0]          rd_rnd;
  logic                accept;

  assign wr_rnd = wcnt[WCNT_W-1:2];
  assign wr_col = wcnt[1:0];

  // Enable is blocked during key_load, so key writes and key reads never
  // touch the same storage in one cycle.
  assign accept = enable & key_ready & ~key_load;

  // A coincident start makes this cycle's enable use round 0.
  assign rd_rnd = start ? 4'd0 : rnd;

  // Serial key schedule load. When key_ready is high, wcnt is already 0, so a
  // new key_load naturally restarts the schedule at word 0.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wcnt      <= '0;
      key_ready <= 1'b0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        rk[i] <= '0;
      end
    end else if (key_load) begin
      case (wr_col)
        2'd0:    rk[wr_rnd][127:96] <= key_word;
        2'd1:    rk[wr_rnd][95:64]  <= key_word;
        2'd2:    rk[wr_rnd][63:32]  <= key_word;
        default: rk[wr_rnd][31:0]   <= key_word;
      endcase
      if (wcnt == LAST_WORD) begin
        wcnt      <= '0;
        key_ready <= 1'b1;
      end else begin
        wcnt      <= wcnt + 1'b1;
        key_ready <= 1'b0;
      end
    end
  end

  // Round counter and registered XOR datapath.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rnd       <= '0;
      data_out  <= '0;
      round_out <= '0;
      valid_out <= 1'b0;
      done      <= 1'b0;
    end else if (accept) begin
      data_out  <= data_in ^ rk[rd_rnd];
      round_out <= rd_rnd;
      valid_out <= 1'b1;
      done      <= (rd_rnd == LAST_RND);
      rnd       <= (rd_rnd == LAST_RND) ? 4'd0 : rd_rnd + 4'd1;
    end else begin
      valid_out <= 1'b0;
      done      <= 1'b0;
      if (start) begin
        rnd <= '0;
      end
    end
  end

endmodule

// File: tb/tb_add_round_key.sv
// Directed bench for add_round_key: hand-computed vectors for reset, gating,
// the FIPS-197 round-0 example, a full round sweep and restart.
module tb_add_round_key;

  logic         clk;
  logic         n_rst;
  logic         key_load;
  logic [31:0]  key_word;
  logic         key_ready;
  logic         start;
  logic         enable;
  logic [127:0] data_in;
  logic [127:0] data_out;
  logic [3:0]   round_out;
  logic         valid_out;
  logic         done;

  int vec_cnt;
  int err_cnt;

  add_round_key #(.NUM_ROUNDS(10)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .key_load  (key_load),
    .key_word  (key_word),
    .key_ready (key_ready),
    .start     (start),
    .enable    (enable),
    .data_in   (data_in),
    .data_out  (data_out),
    .round_out (round_out),
    .valid_out (valid_out),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // compare one observed value against its expected value
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // advance to 1 ns after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [31:0] w);
    key_load = 1'b1;
    key_word = w;
    tick();
    key_load = 1'b0;
  endtask

  function automatic logic [31:0] sweep_word(input int w);
    logic [7:0] b;
    b = 8'(w);
    return {4{b}};
  endfunction

  function automatic logic [127:0] sweep_key(input int r);
    return {sweep_word(4*r), sweep_word(4*r+1), sweep_word(4*r+2), sweep_word(4*r+3)};
  endfunction

  logic [31:0] fips_key [4];

  initial begin
    vec_cnt  = 0;
    err_cnt  = 0;
    n_rst    = 1'b0;
    key_load = 1'b0;
    key_word = '0;
    start    = 1'b0;
    enable   = 1'b0;
    data_in  = '0;
    fips_key[0] = 32'h2b7e1516;
    fips_key[1] = 32'h28aed2a6;
    fips_key[2] = 32'habf71588;
    fips_key[3] = 32'h09cf4f3c;

    #12;
    check("rst_data_out",  data_out,  '0);
    check("rst_round_out", 128'(round_out), '0);
    check("rst_valid",     128'(valid_out), '0);
    check("rst_done",      128'(done),      '0);
    check("rst_key_ready", 128'(key_ready), '0);
    n_rst = 1'b1;
    tick();

    // enable before any key is loaded is rejected
    enable  = 1'b1;
    data_in = 128'hdeadbeef_00000000_11111111_22222222;
    tick();
    enable = 1'b0;
    check("early_en_valid", 128'(valid_out), '0);
    check("early_en_hold",  data_out, '0);

    // FIPS key in words 0..3, sweep pattern elsewhere
    for (int w = 0; w < 43; w++) begin
      load_word(w < 4 ? fips_key[w] : sweep_word(w));
    end
    check("ready_before_43", 128'(key_ready), '0);

    // enable in the word-43 write cycle is rejected
    key_load = 1'b1;
    key_word = sweep_word(43);
    enable   = 1'b1;
    data_in  = 128'h1;
    tick();
    key_load = 1'b0;
    enable   = 1'b0;
    check("w43_en_valid", 128'(valid_out), '0);
    check("w43_ready",    128'(key_ready), 128'd1);
    check("w43_hold",     data_out, '0);

    // FIPS-197 Appendix B round 0
    start   = 1'b1;
    enable  = 1'b1;
    data_in = 128'h3243f6a8885a308d313198a2e0370734;
    tick();
    start  = 1'b0;
    enable = 1'b0;
    check("fips_data",  data_out, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
    check("fips_round", 128'(round_out), '0);
    check("fips_valid", 128'(valid_out), 128'd1);
    check("fips_done",  128'(done), '0);
    tick();
    check("fips_valid_pulse", 128'(valid_out), '0);
    check("fips_hold", data_out, 128'h193de3bea0f4e22b9ac68d2ae9f84808);

    // round 1, then reset with enable still high
    enable  = 1'b1;
    data_in = '0;
    tick();
    check("r1_round", 128'(round_out), 128'd1);
    check("r1_data",  data_out, sweep_key(1));
    n_rst = 1'b0;
    #1;
    check("arst_data",  data_out, '0);
    check("arst_round", 128'(round_out), '0);
    check("arst_valid", 128'(valid_out), '0);
    check("arst_ready", 128'(key_ready), '0);
    enable = 1'b0;
    #2;
    n_rst = 1'b1;
    tick();

    // reset after 20 words: schedule restarts from word 0
    for (int w = 0; w < 20; w++) begin
      load_word(sweep_word(w));
    end
    n_rst = 1'b0;
    #1;
    check("load_rst_ready", 128'(key_ready), '0);
    #2;
    n_rst = 1'b1;
    tick();
    for (int w = 0; w < 43; w++) begin
      load_word(sweep_word(w));
    end
    check("reload_43_ready", 128'(key_ready), '0);
    load_word(sweep_word(43));
    check("reload_44_ready", 128'(key_ready), 128'd1);

    // full sweep: 16 enables walk rounds 0..10 then 0..4
    enable  = 1'b1;
    data_in = '0;
    for (int i = 0; i < 16; i++) begin
      tick();
      check($sformatf("sweep%0d_data", i),  data_out, sweep_key(i % 11));
      check($sformatf("sweep%0d_round", i), 128'(round_out), 128'(i % 11));
      check($sformatf("sweep%0d_valid", i), 128'(valid_out), 128'd1);
      check($sformatf("sweep%0d_done", i),  128'(done), 128'((i % 11) == 10));
    end

    // restart at rnd = 5 coincident with enable
    start   = 1'b1;
    data_in = 128'h0f0f0f0f_f0f0f0f0_00ff00ff_ff00ff00;
    tick();
    start = 1'b0;
    check("restart_round", 128'(round_out), '0);
    check("restart_data",  data_out, data_in ^ sweep_key(0));
    tick();
    check("restart_next_round", 128'(round_out), 128'd1);
    check("restart_next_data",  data_out, data_in ^ sweep_key(1));

    // key_load with enable: load wins, key_ready falls
    key_load = 1'b1;
    key_word = 32'h12345678;
    tick();
    key_load = 1'b0;
    check("ld_en_valid", 128'(valid_out), '0);
    check("ld_en_ready", 128'(key_ready), '0);
    check("ld_en_hold",  data_out, data_in ^ sweep_key(1));
    tick();
    enable = 1'b0;
    check("nr_en_valid", 128'(valid_out), '0);
    check("nr_en_round", 128'(round_out), 128'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/add_round_key.md
# add_round_key

AES-128 AddRoundKey stage with on-chip round-key storage. It sits directly downstream of the MixColumns stage and consumes its 128-bit registered output. On each enabled cycle it XORs the state with the round key for the current round and registers the result. The expanded key schedule (44 × 32-bit words) is loaded serially and held in the block. A round counter selects the key and flags the final round.

## Interface
Parameters:
- NUM_ROUNDS, 10, number of cipher rounds; this block stores NUM_ROUNDS+1 round keys (44 words when NUM_ROUNDS = 10).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- n_rst  input  1  asynchronous, active-low reset.
- key_load  input  1  qualifies key_word as the next expanded-key word.
- key_word  input  32  expanded-key word, words 0..43 in FIPS-197 order.
- key_ready  output  1  high when all 44 words are loaded.
- start  input  1  synchronous; resets the round counter to 0.
- enable  input  1  apply the current round key to data_in this cycle.
- data_in  input  128  state from MixColumns; byte 0 is [127:120], column-major.
- data_out  output  128  registered result.
- round_out  output  4  round index used to produce the current data_out.
- valid_out  output  1  one-cycle pulse: data_out was updated by an accepted enable.
- done  output  1  one-cycle pulse together with valid_out when round_out = NUM_ROUNDS.

## Operation
- Key storage: round key r occupies 128 bits. Word w maps to round r = w/4 and column c = w%4, stored at rk[r][127-32c -: 32].
- Load counter wcnt runs 0..43. Each key_load writes rk at wcnt and increments wcnt.
  - The write at wcnt = 43 sets key_ready and returns wcnt to 0.
- key_load while key_ready = 1 clears key_ready and writes word 0; wcnt becomes 1. A new schedule must be loaded in full.
- Round counter rnd runs 0..NUM_ROUNDS. Accepted enable:
  - data_out <= data_in ^ rk[rnd]
  - round_out <= rnd
  - valid_out <= 1
  - rnd increments, or wraps to 0 after NUM_ROUNDS; done <= 1 on the wrap.
- enable is accepted only when key_ready = 1 and key_load = 0. When not accepted: data_out and round_out hold, valid_out = 0, done = 0, rnd holds.
- start resets rnd to 0. If start and an accepted enable arrive together, the enable uses round 0 and rnd becomes 1.
- There is no bypass path: with enable low, data_out holds its last value.

## Timing
- Reset values: data_out = 0, round_out = 0, valid_out = 0, done = 0, key_ready = 0. Also cleared: wcnt = 0, rnd = 0, all key storage = 0.
- Latency: 1 cycle from accepted enable to data_out, valid_out and done. Throughput is 1 state per cycle.
- key_ready rises the cycle after the word-43 write. An enable in that same write cycle is rejected.
- Reset asserted mid-load or mid-round clears everything immediately. After release, the key schedule must be reloaded from word 0.
- Simultaneous key_load and enable: the load wins and the enable is dropped, with no valid_out.
- Key writes and key reads never alias within a cycle, because enable is blocked during key_load.

## Test plan
- Reset mid-activity: assert n_rst = 0 after loading 20 words and during enable -> all outputs go to 0 asynchronously. After release, key_ready stays 0 until 44 new words are written.
- FIPS-197 Appendix B round 0:
  - Stimulus: load words 0..3 = 2b7e1516 28aed2a6 abf71588 09cf4f3c; words 4..43 arbitrary; start; enable with data_in = 3243f6a8885a308d313198a2e0370734.
  - Response one cycle later: data_out = 193de3bea0f4e22b9ac68d2ae9f84808, round_out = 0, valid_out = 1, done = 0.
- Full round sweep:
  - Stimulus: load word w = {4{8'(w)}}; then 11 consecutive enables with data_in = 0.
  - Response: data_out cycles through the round keys, e.g. round 1 = 04040404050505050606060607070707. round_out steps 0..10. done pulses only with round 10. The 12th enable uses round 0.
- Gating:
  - enable before key_ready -> no valid_out, data_out holds.
  - key_load and enable together -> enable dropped, key_ready falls.
  - enable in the cycle of the word-43 write -> rejected.
- Restart: start mid-sequence at rnd = 5, coincident with enable -> round_out = 0, and the next enable uses round 1.
